// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, status-counter
// width and the helpers used to size and saturate counters.
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLLRST   = 2'd0,
        WAITLOCK = 2'd1,
        STABLE   = 2'd2,
        RUN      = 2'd3
    } pll_state_e;

    localparam int              SAT_W   = 8;
    localparam logic [SAT_W-1:0] SAT_MAX = 8'hFF;

    // Width of the shared phase counter: enough to hold the largest terminal count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v);
        return (v == SAT_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_sync_bit.sv
// Multi-flop synchronizer bringing a single asynchronous level into the clk domain.
module pll_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    // Fewer than two flops gives no metastability protection, so clamp the depth.
    localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], d};
        end
    end

    assign q = r_sync[DEPTH-1];

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for and qualifies lock, and
// releases the downstream system reset only while lock stays qualified.
module pll_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE     = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [1:0]       state_o,
    output logic [SAT_W-1:0] timeout_count,
    output logic [SAT_W-1:0] relock_count
);

    localparam int               CNT_W       = cnt_width(RST_PULSE, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    pll_state_e       r_state;
    pll_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [SAT_W-1:0] r_timeout_cnt;
    logic [SAT_W-1:0] r_relock_cnt;
    logic             r_pll_rst;
    logic             r_sys_rst;
    logic             r_ready;
    logic             w_lock_s;
    logic             w_timeout_hit;
    logic             w_relock_hit;

    pll_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (w_lock_s)
    );

    // Next-state logic; lock wins over a coinciding timeout in WAITLOCK.
    always_comb begin
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        w_relock_hit  = 1'b0;
        case (r_state)
            PLLRST: begin
                if (r_cnt == RST_LAST) begin
                    w_next = WAITLOCK;
                end else begin
                    w_next = PLLRST;
                end
            end
            WAITLOCK: begin
                if (w_lock_s) begin
                    w_next = STABLE;
                end else if (r_cnt == TO_LAST) begin
                    w_next        = PLLRST;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_next = WAITLOCK;
                end
            end
            STABLE: begin
                if (!w_lock_s) begin
                    w_next = WAITLOCK;
                end else if (r_cnt == STABLE_LAST) begin
                    w_next = RUN;
                end else begin
                    w_next = STABLE;
                end
            end
            RUN: begin
                if (!w_lock_s) begin
                    w_next       = PLLRST;
                    w_relock_hit = 1'b1;
                end else begin
                    w_next = RUN;
                end
            end
            default: begin
                w_next = PLLRST;
            end
        endcase
    end

    // State, shared phase counter, status counts and next-state-decoded outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state       <= PLLRST;
            r_cnt         <= '0;
            r_timeout_cnt <= '0;
            r_relock_cnt  <= '0;
            r_pll_rst     <= 1'b1;
            r_sys_rst     <= 1'b1;
            r_ready       <= 1'b0;
        end else begin
            r_state <= w_next;
            // The counter freezes in RUN so it can never run past its width.
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state != RUN) begin
                r_cnt <= r_cnt + CNT_ONE;
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_timeout_hit) begin
                r_timeout_cnt <= sat_inc(r_timeout_cnt);
            end else begin
                r_timeout_cnt <= r_timeout_cnt;
            end
            if (w_relock_hit) begin
                r_relock_cnt <= sat_inc(r_relock_cnt);
            end else begin
                r_relock_cnt <= r_relock_cnt;
            end
            r_pll_rst <= (w_next == PLLRST);
            r_sys_rst <= (w_next != RUN);
            r_ready   <= (w_next == RUN);
        end
    end

    assign pll_rst       = r_pll_rst;
    assign sys_rst       = r_sys_rst;
    assign ready         = r_ready;
    assign state_o       = r_state;
    assign timeout_count = r_timeout_cnt;
    assign relock_count  = r_relock_cnt;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq: table of lock-arrival cases with a
// scoreboard queue, plus hand-written timeout, chatter, relock and async-reset runs.
module tb_pll_reset_seq;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state_o;
    logic [7:0] timeout_count;
    logic [7:0] relock_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int delay;     // cycles after pll_rst falls until pll_locked rises
        int exp_fall;  // cycles from pll_locked rise to sys_rst low
        int exp_to;    // timeout_count once in RUN
    } vec_t;

    vec_t vecs[6];
    vec_t sb[$];

    pll_reset_seq #(
        .RST_PULSE     (16),
        .LOCK_TIMEOUT  (200),
        .STABLE_CYCLES (32),
        .SYNC_STAGES   (2)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_rst       (sys_rst),
        .ready         (ready),
        .state_o       (state_o),
        .timeout_count (timeout_count),
        .relock_count  (relock_count)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Hold rst for two cycles with lock low; returns at the releasing negedge.
    task automatic do_reset();
        @(negedge refclk);
        pll_locked = 1'b0;
        rst        = 1'b1;
        repeat (2) @(negedge refclk);
        rst = 1'b0;
    endtask

    // Count negedges (including the current one) while pll_rst stays high.
    task automatic measure_pll_rst(output int h);
        h = 1;
        do begin
            @(negedge refclk);
            if (pll_rst) h++;
        end while (pll_rst && h < 500);
    endtask

    task automatic wait_sys_low(output int c);
        c = 0;
        while (sys_rst && c < 600) begin
            @(negedge refclk);
            c++;
        end
    endtask

    initial begin
        int   h, c, n_gap_err, n_len_err, n_sys_err;
        int   seen_wait, st3, st6, p2, p3, s3, rl3, rd3;
        vec_t e;

        vecs[0] = '{delay: 10,  exp_fall: 35, exp_to: 0};
        vecs[1] = '{delay: 150, exp_fall: 35, exp_to: 0};
        vecs[2] = '{delay: 197, exp_fall: 35, exp_to: 0};  // lock_s seen at cnt==199
        vecs[3] = '{delay: 198, exp_fall: 51, exp_to: 1};  // one cycle late: timeout
        vecs[4] = '{delay: 205, exp_fall: 44, exp_to: 1};  // lock during retry pulse
        vecs[5] = '{delay: 250, exp_fall: 35, exp_to: 1};

        rst        = 1'b1;
        pll_locked = 1'b0;
        #5;
        check("reset_pll_rst", int'(pll_rst), 1);
        check("reset_sys_rst", int'(sys_rst), 1);
        check("reset_ready", int'(ready), 0);
        check("reset_state", int'(state_o), 0);
        check("reset_counts", int'(timeout_count) + int'(relock_count), 0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            measure_pll_rst(h);
            check($sformatf("v%0d_pll_rst_len", i), h, 16);
            repeat (vecs[i].delay) @(negedge refclk);
            pll_locked = 1'b1;
            sb.push_back(vecs[i]);
            wait_sys_low(c);
            e = sb.pop_front();
            check($sformatf("v%0d_sys_rst_fall", i), c, e.exp_fall);
            check($sformatf("v%0d_timeouts", i), int'(timeout_count), e.exp_to);
            check($sformatf("v%0d_relocks", i), int'(relock_count), 0);
            check($sformatf("v%0d_ready", i), int'(ready), 1);
            check($sformatf("v%0d_state", i), int'(state_o), 3);
        end

        // Lock never arrives: periodic retries and saturating timeout count.
        do_reset();
        measure_pll_rst(h);
        n_gap_err = 0;
        n_len_err = 0;
        n_sys_err = 0;
        for (int k = 1; k <= 300; k++) begin
            c = 0;
            while (!pll_rst && c < 400) begin
                @(negedge refclk);
                c++;
                if (!sys_rst) n_sys_err++;
            end
            if (c != 200) n_gap_err++;
            if (k <= 3 || k == 254 || k == 255 || k == 256 || k == 300)
                check($sformatf("to_count_%0d", k), int'(timeout_count), (k > 255) ? 255 : k);
            measure_pll_rst(h);
            if (h != 16) n_len_err++;
            if (k == 1) check("to_pulse_len", h, 16);
        end
        check("to_gap_errors", n_gap_err, 0);
        check("to_len_errors", n_len_err, 0);
        check("to_sys_rst_low", n_sys_err, 0);

        // Lock chatter in STABLE: back to WAITLOCK, then a fresh qualification.
        do_reset();
        measure_pll_rst(h);
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        c = 0;
        while (state_o != 2'd2 && c < 100) begin
            @(negedge refclk);
            c++;
        end
        check("ch_reach_stable", int'(state_o), 2);
        repeat (20) @(negedge refclk);
        pll_locked = 1'b0;
        c = 0; seen_wait = 0; st3 = -1; st6 = -1;
        while (sys_rst && c < 200) begin
            @(negedge refclk);
            c++;
            if (state_o == 2'd1) seen_wait = 1;
            if (c == 3) begin
                st3        = int'(state_o);
                pll_locked = 1'b1;
            end
            if (c == 6) st6 = int'(state_o);
        end
        check("ch_state_waitlock", st3, 1);
        check("ch_state_restable", st6, 2);
        check("ch_seen_waitlock", seen_wait, 1);
        check("ch_sys_rst_fall", c, 38);
        check("ch_counts", int'(timeout_count) + int'(relock_count), 0);

        // Single-cycle lock drop in RUN forces a full PLL reset and relock.
        @(negedge refclk);
        pll_locked = 1'b0;
        c = 0; p2 = -1; p3 = -1; s3 = -1; rl3 = -1; rd3 = -1;
        do begin
            @(negedge refclk);
            c++;
            if (c == 1) pll_locked = 1'b1;
            if (c == 2) p2 = int'(pll_rst);
            if (c == 3) begin
                p3  = int'(pll_rst);
                s3  = int'(sys_rst);
                rl3 = int'(relock_count);
                rd3 = int'(ready);
            end
        end while ((c < 4 || sys_rst) && c < 300);
        check("rl_pll_rst_before", p2, 0);
        check("rl_pll_rst", p3, 1);
        check("rl_sys_rst", s3, 1);
        check("rl_ready_low", rd3, 0);
        check("rl_relock_count", rl3, 1);
        check("rl_sys_rst_fall", c, 52);
        check("rl_ready", int'(ready), 1);

        // Short asynchronous reset between edges while in RUN.
        @(negedge refclk);
        #2 rst = 1'b1;
        #6;
        check("ar_pll_rst", int'(pll_rst), 1);
        check("ar_sys_rst", int'(sys_rst), 1);
        check("ar_ready", int'(ready), 0);
        check("ar_state", int'(state_o), 0);
        check("ar_counts", int'(timeout_count) + int'(relock_count), 0);
        rst = 1'b0;
        h = 0;
        forever begin
            @(negedge refclk);
            if (!pll_rst || h >= 100) break;
            h++;
        end
        check("ar_pll_rst_len", h, 15);
        wait_sys_low(c);
        check("ar_sys_rst_fall", c, 33);
        check("ar_ready", int'(ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
